turbo_frame_ctrl: RTL and testbench
===================================

TURBO_FRAME_CTRL -- requirements
Module: turbo_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, meaning bytes per frame (power of two, 2..16).
REQ-002 SHALL have parameter INTLV_MULT, default 3, meaning interleaver multiplier (odd, so the index map is a permutation).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  8  frame byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a byte.
REQ-008 SHALL have port abort  input  1  synchronous frame flush.
REQ-009 SHALL have port out_data  output  16  encoded word {systematic[7:0], parity1[3:0], parity2[3:0]}.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts the word.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the last word of a frame is accepted.

Function
REQ-014 SHALL implement states IDLE, FILL, ENCODE, DONE.
REQ-015 IDLE: in_ready=1; an accepted byte is written to buf[0] and moves the block to FILL with wr_idx=1.
REQ-016 FILL: in_ready=1; each accepted byte goes to buf[wr_idx] and increments wr_idx; acceptance of byte FRAME_LEN-1 moves the block to ENCODE with rd_idx=0.
REQ-017 ENCODE: in_ready=0; out_valid=1; out_data = {buf[rd_idx], P(buf[rd_idx]), P(buf[pi(rd_idx)])}, where pi(i) = (i*INTLV_MULT) mod FRAME_LEN, computed in log2(FRAME_LEN) bits with wrap.
REQ-018 P(d) SHALL be 4-bit parity: p0=d0^d1^d2, p1=d2^d3^d4, p2=d4^d5^d6, p3=d6^d7^d0.
REQ-019 Each out_valid&&out_ready increments rd_idx; acceptance at rd_idx=FRAME_LEN-1 moves the block to DONE.
REQ-020 out_valid SHALL rise the cycle after the last input byte is accepted (latency 1); words emit at one per cycle under continuous out_ready.
REQ-021 Under out_ready=0, out_data and out_valid SHALL hold stable until accepted.
REQ-022 DONE: frame_done=1 for exactly one cycle, out_valid=0, in_ready=0; the block returns to IDLE on the next cycle.
REQ-023 abort=1 in any state SHALL move the block to IDLE next cycle, clear wr_idx/rd_idx, and deassert out_valid; buffer contents need not be cleared.
REQ-024 abort coincident with an input or output handshake SHALL win: the transfer is not counted, and frame_done SHALL NOT pulse.
REQ-025 in_valid while in_ready=0 SHALL be ignored; no byte is lost or overwritten.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, wr_idx=0, rd_idx=0, out_valid=0, frame_done=0, busy=0, out_data=16'h0000.
REQ-027 in_ready SHALL read 1 once rst_n is released, and buffer contents SHALL be don't-care.
REQ-028 Reset asserted mid-FILL or mid-ENCODE SHALL discard the partial frame with no output.

Structure
REQ-029 A shared package SHALL hold the state enum, the default FRAME_LEN/INTLV_MULT constants, and the out_data field widths.
REQ-030 Parity function P SHALL be a combinational sub-module turbo_parity4 (8-bit in, 4-bit out), instantiated twice (natural and interleaved paths).
REQ-031 The frame buffer SHALL be a flop array, not an inferred macro.

Verification
REQ-032 Frame 0x00..0x07 with out_ready=1 -> words 0x0000, 0x0198, ... in order; pi sequence 0,3,6,1,4,7,2,5; frame_done one pulse.
REQ-033 Frame of all 0xFF -> eight words 0xFFFF, then frame_done, then in_ready=1.
REQ-034 Frame 0x00..0x07 with out_ready toggled 1/0 per cycle -> same eight words, each held stable while out_ready=0, none dropped or duplicated.
REQ-035 abort during rd_idx=3 of ENCODE -> out_valid=0 next cycle, IDLE, no frame_done; next frame encodes correctly from index 0.
REQ-036 rst_n pulsed low after 5 FILL bytes -> all outputs at reset values immediately; new 8-byte frame -> correct 8 words.
REQ-037 in_valid held high during ENCODE with byte 0xAA -> byte ignored; first byte of the next frame is the first byte presented after DONE.

Source files
------------

// File: rtl/turbo_frame_ctrl_pkg.sv
// Shared types and constants for the turbo frame controller: FSM states,
// default frame geometry and the layout of the encoded output word.
package turbo_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_ENCODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_FRAME_LEN  = 8;
    localparam int DEF_INTLV_MULT = 3;

    localparam int SYS_W  = 8;
    localparam int PAR_W  = 4;
    localparam int WORD_W = SYS_W + 2 * PAR_W;

    typedef struct packed {
        logic [SYS_W-1:0] systematic;
        logic [PAR_W-1:0] parity1;
        logic [PAR_W-1:0] parity2;
    } enc_word_t;

endpackage

// File: rtl/turbo_parity4.sv
// Combinational 4-bit overlapping-triplet parity over one byte.
module turbo_parity4
    import turbo_frame_ctrl_pkg::*;
(
    input  logic [SYS_W-1:0] data,
    output logic [PAR_W-1:0] parity
);

    assign parity[0] = data[0] ^ data[1] ^ data[2];
    assign parity[1] = data[2] ^ data[3] ^ data[4];
    assign parity[2] = data[4] ^ data[5] ^ data[6];
    assign parity[3] = data[6] ^ data[7] ^ data[0];

endmodule

// File: rtl/turbo_frame_ctrl.sv
// Frame buffer + FSM: collects FRAME_LEN bytes, then emits one encoded word
// per byte carrying natural-order and interleaved-order parity.
module turbo_frame_ctrl
    import turbo_frame_ctrl_pkg::*;
#(
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int INTLV_MULT = DEF_INTLV_MULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SYS_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    // Multiplying in IDX_W bits gives the mod-FRAME_LEN wrap for free.
    localparam logic [IDX_W-1:0] MULT_W   = IDX_W'(INTLV_MULT);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
    logic [IDX_W-1:0] pi_idx;
    logic             wr_en;

    logic [SYS_W-1:0] frame_buf [FRAME_LEN];

    logic [SYS_W-1:0] par_in  [2];
    logic [PAR_W-1:0] par_out [2];
    enc_word_t        enc_word;

    assign pi_idx    = rd_idx_reg * MULT_W;
    assign par_in[0] = frame_buf[rd_idx_reg];
    assign par_in[1] = frame_buf[pi_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_parity
            turbo_parity4 u_parity (
                .data   (par_in[gi]),
                .parity (par_out[gi])
            );
        end
    endgenerate

    always_comb begin
        enc_word.systematic = par_in[0];
        enc_word.parity1    = par_out[0];
        enc_word.parity2    = par_out[1];
    end

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        wr_en       = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        frame_done  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en       = 1'b1;
                    wr_idx_next = wr_idx_reg + IDX_W'(1);
                    state_next  = ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_reg == LAST_IDX) begin
                        wr_idx_next = '0;
                        rd_idx_next = '0;
                        state_next  = ST_ENCODE;
                    end else begin
                        wr_idx_next = wr_idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_ENCODE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (rd_idx_reg == LAST_IDX) begin
                        rd_idx_next = '0;
                        state_next  = ST_DONE;
                    end else begin
                        rd_idx_next = rd_idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort overrides any handshake in the same cycle, including the
        // final output word, so DONE is never reached on an aborted frame.
        if (abort) begin
            wr_en       = 1'b0;
            wr_idx_next = '0;
            rd_idx_next = '0;
            state_next  = ST_IDLE;
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign out_data = out_valid ? enc_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
        end
    end

    // Frame storage carries no reset; its contents are meaningless until refilled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame_buf[wr_idx_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// Randomized self-checking bench for turbo_frame_ctrl against a frame-level model.
module tb_turbo_frame_ctrl;

    localparam int FL      = 8;
    localparam int MULT    = 3;
    localparam int CYC_MAX = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    turbo_frame_ctrl #(.FRAME_LEN(FL), .INTLV_MULT(MULT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  frame [FL];
    logic [15:0] got_q [$];
    int          unstable;
    int          drain_timeout;
    int          drv_timeout = 0;

    // Reference: parity bits straight from the triplet equations.
    function automatic logic [3:0] ref_parity(input logic [7:0] d);
        return {d[6] ^ d[7] ^ d[0], d[4] ^ d[5] ^ d[6],
                d[2] ^ d[3] ^ d[4], d[0] ^ d[1] ^ d[2]};
    endfunction

    function automatic logic [15:0] ref_word(input int i);
        int j;
        j = (i * MULT) % FL;
        return {frame[i], ref_parity(frame[i]), ref_parity(frame[j])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < FL; i++) frame[i] = 8'($urandom);
    endtask

    task automatic drive_frame();
        for (int i = 0; i < FL; i++) begin
            int cyc;
            cyc = 0;
            in_valid = 1'b1;
            in_data  = frame[i];
            while (in_ready !== 1'b1 && cyc < 50) begin
                tick();
                cyc++;
            end
            if (cyc >= 50) drv_timeout++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle ready, 2: random ready
    task automatic drain(input int mode);
        logic [15:0] prev;
        bit          stalled;
        int          cyc;
        prev = '0;
        stalled = 0;
        cyc = 0;
        got_q.delete();
        unstable = 0;
        drain_timeout = 0;
        while (got_q.size() < FL && cyc < CYC_MAX) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled && (out_valid !== 1'b1 || out_data !== prev)) unstable++;
            if (out_valid === 1'b1 && out_ready) begin
                got_q.push_back(out_data);
                stalled = 0;
            end else begin
                stalled = (out_valid === 1'b1);
                prev = out_data;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= CYC_MAX) drain_timeout = 1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_ramp_frame();
        for (int i = 0; i < FL; i++) frame[i] = 8'(i);
        drive_frame();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ramp_latency out_valid got=%b want=1", out_valid); end
        drain(0);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL ramp_count got=%0d want=%0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL ramp_word[%0d] got=%h want=%h", i, got_q[i], ref_word(i)); end
        end
        if (got_q.size() >= 2) begin
            total++; if (got_q[0] !== 16'h0000) begin bad++; $display("FAIL ramp_word0_const got=%h want=0000", got_q[0]); end
            total++; if (got_q[1] !== 16'h0198) begin bad++; $display("FAIL ramp_word1_const got=%h want=0198", got_q[1]); end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ramp_frame_done got=%b want=1", frame_done); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ramp_done_in_ready got=%b want=0", in_ready); end
        tick();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ramp_done_pulse got=%b want=0", frame_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ramp_idle_busy got=%b want=0", busy); end
        $display("test_ramp_frame: %0d words", got_q.size());
    endtask

    task automatic test_all_ff();
        for (int i = 0; i < FL; i++) frame[i] = 8'hFF;
        drive_frame();
        drain(0);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL ff_count got=%0d want=%0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== 16'hFFFF) begin bad++; $display("FAIL ff_word[%0d] got=%h want=ffff", i, got_q[i]); end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ff_frame_done got=%b want=1", frame_done); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ff_in_ready got=%b want=1", in_ready); end
        $display("test_all_ff: %0d words", got_q.size());
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < FL; i++) frame[i] = 8'(i);
        drive_frame();
        drain(1);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), FL); end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold_unstable got=%0d want=0", unstable); end
        total++; if (drain_timeout != 0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", drain_timeout); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i], ref_word(i)); end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bp_frame_done got=%b want=1", frame_done); end
        tick();
        $display("test_backpressure: %0d words", got_q.size());
    endtask

    task automatic test_abort();
        fill_random();
        drive_frame();
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        total++; if (out_data !== ref_word(3)) begin bad++; $display("FAIL abort_word3 got=%h want=%h", out_data, ref_word(3)); end
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL abort_frame_done got=%b want=0", frame_done); end
        tick();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL abort_late_done got=%b want=0", frame_done); end
        fill_random();
        drive_frame();
        drain(0);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL abort_next_count got=%0d want=%0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL abort_next_word[%0d] got=%h want=%h", i, got_q[i], ref_word(i)); end
        end
        tick();
        $display("test_abort: %0d words after abort", got_q.size());
    endtask

    task automatic test_reset_mid_frame();
        fill_random();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = frame[i];
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfill_busy got=%b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfill_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rstfill_out_data got=%h want=0000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fill_random();
        drive_frame();
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstenc_out_valid got=%b want=0", out_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rstenc_frame_done got=%b want=0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstenc_in_ready got=%b want=1", in_ready); end
        fill_random();
        drive_frame();
        drain(2);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL rst_next_count got=%0d want=%0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL rst_next_word[%0d] got=%h want=%h", i, got_q[i], ref_word(i)); end
        end
        tick();
        $display("test_reset_mid_frame: %0d words after reset", got_q.size());
    endtask

    task automatic test_ignore_in_encode();
        fill_random();
        drive_frame();
        in_valid = 1'b1;
        in_data = 8'hAA;
        drain(1);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL ign_count got=%0d want=%0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL ign_word[%0d] got=%h want=%h", i, got_q[i], ref_word(i)); end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_done_in_ready got=%b want=0", in_ready); end
        in_valid = 1'b0;
        tick();
        fill_random();
        drive_frame();
        drain(0);
        total++; if (got_q.size() != FL) begin bad++; $display("FAIL ign_next_count got=%0d want=%0d", got_q.size(), FL); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL ign_next_word[%0d] got=%h want=%h", i, got_q[i], ref_word(i)); end
        end
        tick();
        $display("test_ignore_in_encode: %0d words in next frame", got_q.size());
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            fill_random();
            drive_frame();
            drain(2);
            total++; if (got_q.size() != FL) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", f, got_q.size(), FL); end
            total++; if (unstable != 0) begin bad++; $display("FAIL b2b_hold[%0d] got=%0d want=0", f, unstable); end
            for (int i = 0; i < got_q.size(); i++) begin
                total++; if (got_q[i] !== ref_word(i)) begin bad++; $display("FAIL b2b_word[%0d][%0d] got=%h want=%h", f, i, got_q[i], ref_word(i)); end
            end
            total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done[%0d] got=%b want=1", f, frame_done); end
            $display("test_back_to_back: frame %0d, %0d words", f, got_q.size());
        end
        tick();
        total++; if (drv_timeout != 0) begin bad++; $display("FAIL drive_timeout got=%0d want=0", drv_timeout); end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_all_ff();
        test_backpressure();
        test_abort();
        test_reset_mid_frame();
        test_ignore_in_encode();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
